conc_trace_capture: RTL and testbench

Response-side capture unit for the concolic AES benches. It sits on the DUT outputs opposite the opcode-driven stimulus player. On each cycle where the observe strobe is high, it samples a cycle stamp, the 128-bit cipher output and the 64-bit capacitance side channel into a record FIFO. Records are drained as 32-bit beats over a valid/ready stream for logging or comparison.

---
 rtl/conc_trace_capture.sv | 203 ++++++++++++++++++++
 tb/tb_conc_trace_capture.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conc_trace_capture.sv
// conc_trace_capture
// Response-side capture unit for the concolic AES benches. Each cycle with obs
// high samples {cycle stamp, cipher output, capacitance side channel} into a
// record FIFO. Records are drained MSB-first as seven 32-bit beats over a
// valid/ready stream.
//
// Build option:
//   CONC_CAPTURE_DEDUP_EN - when defined, a sample is pushed only if
//                           {out, Capacitance} differs from the last pushed
//                           pair. The first sample after reset is always pushed.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-low reset
//   obs          observe strobe, sample this cycle when high
//   out          DUT cipher output (128)
//   Capacitance  DUT side-channel output (64)
//   m_valid      beat valid
//   m_data       beat payload (32)
//   m_last       final beat of a record
//   m_ready      consumer accepts beat
//   level        records held in the FIFO, not counting the serializer
//   overflow     sticky, a sample was dropped
//   drop_count   dropped samples, saturating at 16'hFFFF
//
// Serializer states:
//   state  | meaning
//   S_IDLE | holding register empty, waiting for a FIFO record
//   S_SEND | presenting beat 'beat' (0..6) of the held record
module conc_trace_capture #(
    parameter int DEPTH = 8,
    parameter int CW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     obs,
    input  logic [127:0]             out,
    input  logic [63:0]              Capacitance,
    output logic                     m_valid,
    output logic [31:0]              m_data,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = CW + 192;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t          state;
    logic [2:0]      beat;
    logic [RW-1:0]   hold;
    logic [CW-1:0]   cyc;

    logic [RW-1:0]   mem [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic [RW-1:0]   head;

    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            cand;

    function automatic logic [31:0] beat_word(input logic [RW-1:0] rec,
                                              input logic [2:0] idx);
        logic [31:0] w;
        case (idx)
            3'd0:    w = rec[223:192];
            3'd1:    w = rec[191:160];
            3'd2:    w = rec[159:128];
            3'd3:    w = rec[127:96];
            3'd4:    w = rec[95:64];
            3'd5:    w = rec[63:32];
            default: w = rec[31:0];
        endcase
        return w;
    endfunction

    assign head  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

    // The serializer takes the head record either from idle or straight after
    // the last beat of the current record is accepted (no bubble).
    assign pop = !empty &&
                 ((state == S_IDLE) ||
                  ((state == S_SEND) && m_ready && (beat == 3'd6)));

    // A full FIFO still accepts a push when the serializer pops that cycle.
    assign push = cand && (!full || pop);

`ifdef CONC_CAPTURE_DEDUP_EN
    logic [191:0] last_pair;
    logic         last_valid;

    assign cand = obs && (!last_valid || ({out, Capacitance} != last_pair));

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_valid <= 1'b0;
            last_pair  <= '0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_pair  <= {out, Capacitance};
        end
    end
`else
    assign cand = obs;
`endif

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wptr[AW-1:0]] <= {cyc, out, Capacitance};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            cyc <= cyc + 1'b1;
            if (cand && !push) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // m_data/m_last are registered: the next beat word is selected here so
    // m_ready never reaches the outputs combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            beat    <= '0;
            hold    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        hold    <= head;
                        beat    <= '0;
                        m_valid <= 1'b1;
                        m_data  <= beat_word(head, 3'd0);
                        m_last  <= 1'b0;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (m_ready) begin
                        if (beat != 3'd6) begin
                            beat   <= beat + 3'd1;
                            m_data <= beat_word(hold, beat + 3'd1);
                            m_last <= (beat == 3'd5);
                        end else if (!empty) begin
                            hold    <= head;
                            beat    <= '0;
                            m_valid <= 1'b1;
                            m_data  <= beat_word(head, 3'd0);
                            m_last  <= 1'b0;
                        end else begin
                            beat    <= '0;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conc_trace_capture.sv
module tb_conc_trace_capture;

    localparam int DEPTH = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    obs;
    logic [127:0]            out;
    logic [63:0]             Capacitance;
    logic                    m_valid;
    logic [31:0]             m_data;
    logic                    m_last;
    logic                    m_ready;
    logic [$clog2(DEPTH):0]  level;
    logic                    overflow;
    logic [15:0]             drop_count;

    always #5 clk = ~clk;

    conc_trace_capture #(.DEPTH(DEPTH), .CW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .obs         (obs),
        .out         (out),
        .Capacitance (Capacitance),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          beats_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_expect(input logic [31:0] stamp, input logic [127:0] o, input logic [63:0] c);
        exp_q.push_back('{stamp, 1'b0});
        exp_q.push_back('{o[127:96], 1'b0});
        exp_q.push_back('{o[95:64], 1'b0});
        exp_q.push_back('{o[63:32], 1'b0});
        exp_q.push_back('{o[31:0], 1'b0});
        exp_q.push_back('{c[63:32], 1'b0});
        exp_q.push_back('{c[31:0], 1'b1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic obs_val);
        rst     = 1'b0;
        obs     = obs_val;
        m_ready = 1'b0;
        repeat (3) tick();
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name, input int budget, input bit toggle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            if (toggle) m_ready = ~m_ready;
            tick();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: drain timeout, got %0d beats pending expected 0", name, exp_q.size());
        end
    endtask

    // Monitor: a beat presented with m_ready high at this negedge is taken at
    // the next rising edge, so it is checked against the scoreboard here.
    always @(negedge clk) begin
        beat_t e;
        if (prev_stall && m_valid) begin
            tests++;
            if (m_data !== prev_data || m_last !== prev_last) begin
                fails++;
                $display("FAIL stall_stable: got %h/%b expected %h/%b", m_data, m_last, prev_data, prev_last);
            end
        end
        if (rst && m_valid && m_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got %h expected no beat", m_data);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.data || m_last !== e.last) begin
                    fails++;
                    $display("FAIL beat: got %h last=%b expected %h last=%b", m_data, m_last, e.data, e.last);
                end
            end
            beats_seen++;
        end
        prev_stall = rst && m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k_out;
        logic [63:0]  k_cap;
        int           base;
        int           n;

        rst = 1'b0; obs = 1'b0; out = '0; Capacitance = '0; m_ready = 1'b0;

        // Reset with obs high: nothing captured, all outputs zero.
        out = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
        Capacitance = 64'h1234_5678_9ABC_DEF0;
        reset_dut(1'b1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);

        // Single record sampled on the first post-reset edge carries stamp 0.
        rst = 1'b1; obs = 1'b1; m_ready = 1'b1;
        out = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
        Capacitance = 64'hDEAD_BEEF_0123_4567;
        push_expect(32'd0, out, Capacitance);
        tick();
        obs = 1'b0;
        check("single_level_after_push", 32'(level), 32'd1);
        check("single_valid_before_load", 32'(m_valid), 32'd0);
        tick();
        check("single_valid_after_load", 32'(m_valid), 32'd1);
        check("single_level_after_load", 32'(level), 32'd0);
        wait_drain("single_drain", 50, 1'b0);
        repeat (3) tick();
        check("single_no_extra", 32'(m_valid), 32'd0);

        // Backpressure: m_ready toggles every cycle.
        reset_dut(1'b0);
        rst = 1'b1; obs = 1'b1; m_ready = 1'b1;
        out = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        Capacitance = 64'hCAFE_F00D_8BAD_F00D;
        push_expect(32'd0, out, Capacitance);
        tick();
        obs = 1'b0;
        wait_drain("backpressure_drain", 100, 1'b1);
        m_ready = 1'b1;

        // Overflow: 12 samples with no drain -> stamps 0..8 kept, 3 dropped.
        reset_dut(1'b0);
        rst = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            obs = 1'b1;
            out = {4{i[31:0]}};
            Capacitance = {2{~i[31:0]}};
            if (i <= 8) push_expect(i[31:0], out, Capacitance);
            tick();
            if (i == 8) check("ovf_not_yet", 32'(overflow), 32'd0);
            if (i == 9) begin
                check("ovf_first_drop", 32'(overflow), 32'd1);
                check("ovf_first_count", 32'(drop_count), 32'd1);
            end
        end
        obs = 1'b0;
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_drop_count", 32'(drop_count), 32'd3);
        check("ovf_level", 32'(level), 32'd8);
        m_ready = 1'b1;
        wait_drain("ovf_drain", 200, 1'b0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_level_drained", 32'(level), 32'd0);

        // Dedup: five identical samples then one change.
        reset_dut(1'b0);
        rst = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            obs = 1'b1;
            out = (i < 5) ? 128'hAAAA_0000_BBBB_1111_CCCC_2222_DDDD_3333
                          : 128'hAAAA_0000_BBBB_1111_CCCC_2222_DDDD_3334;
            Capacitance = 64'h0F0F_F0F0_5A5A_A5A5;
`ifdef CONC_CAPTURE_DEDUP_EN
            if (i == 0 || i == 5) push_expect(i[31:0], out, Capacitance);
`else
            push_expect(i[31:0], out, Capacitance);
`endif
            tick();
        end
        obs = 1'b0;
        wait_drain("dedup_drain", 200, 1'b0);
        check("dedup_drop_count", 32'(drop_count), 32'd0);

        // Reset in the middle of a record, with a second record queued.
        reset_dut(1'b0);
        rst = 1'b1; m_ready = 1'b1;
        base = beats_seen;
        k_out = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        k_cap = 64'h5555_AAAA_3333_CCCC;
        obs = 1'b1; out = k_out; Capacitance = k_cap;
        push_expect(32'd0, k_out, k_cap);
        tick();
        out = ~k_out;
        push_expect(32'd1, ~k_out, k_cap);
        tick();
        obs = 1'b0;
        n = 0;
        while (beats_seen < base + 4 && n < 50) begin
            tick();
            n++;
        end
        check("midrst_beats_reached", 32'(beats_seen - base), 32'd4);
        rst = 1'b0; m_ready = 1'b0;
        exp_q.delete();
        tick();
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_last", 32'(m_last), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        rst = 1'b1;
        tick();
        check("midrst_level_after_release", 32'(level), 32'd0);
        m_ready = 1'b1;
        repeat (4) tick();
        check("midrst_no_beats", 32'(m_valid), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
